// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle RV32I datapath: sequences fetch,
// execute, memory and write-back, drives datapath enables, counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } stateT;

  typedef enum logic [3:0] {
    OP_ALUREG, OP_ALUIMM, OP_BRANCH, OP_JALR, OP_JAL,
    OP_AUIPC, OP_LUI, OP_LOAD, OP_STORE, OP_ILLEGAL
  } opClassT;

  stateT      curState;
  opClassT    opClass;
  logic [1:0] classASel;
  logic       classBSel;
  logic       unusedInstBits;

  assign unusedInstBits = ^inst[31:7];

  always_comb begin
    case (inst[6:0])
      7'b0110011: opClass = OP_ALUREG;
      7'b0010011: opClass = OP_ALUIMM;
      7'b1100011: opClass = OP_BRANCH;
      7'b1100111: opClass = OP_JALR;
      7'b1101111: opClass = OP_JAL;
      7'b0010111: opClass = OP_AUIPC;
      7'b0110111: opClass = OP_LUI;
      7'b0000011: opClass = OP_LOAD;
      7'b0100011: opClass = OP_STORE;
      default:    opClass = OP_ILLEGAL;
    endcase
  end

  // ALU operand selection per class; reused by EXEC, MEM and non-load WB.
  always_comb begin
    classASel = 2'b00;
    classBSel = 1'b1;
    case (opClass)
      OP_ALUREG:                 classBSel = 1'b0;
      OP_LUI:                    classASel = 2'b10;
      OP_AUIPC, OP_BRANCH, OP_JAL: classASel = 2'b01;
      default:                   classASel = 2'b00;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    alu_a_sel = 2'b00;
    alu_b_sel = 1'b0;
    retire    = 1'b0;
    case (curState)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      EXEC: begin
        alu_a_sel = classASel;
        alu_b_sel = classBSel;
        if (opClass == OP_BRANCH) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          retire   = 1'b1;
        end else if (opClass == OP_JAL || opClass == OP_JALR) begin
          pc_write  = 1'b1;
          pc_sel    = 1'b1;
          reg_write = 1'b1;
          wb_sel    = 2'b10;
          retire    = 1'b1;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (opClass == OP_STORE);
        alu_a_sel = classASel;
        alu_b_sel = classBSel;
        if (mem_ready) begin
          if (opClass == OP_LOAD) begin
            mdr_write = 1'b1;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (opClass == OP_LOAD) begin
          wb_sel = 2'b01;
        end else begin
          alu_a_sel = classASel;
          alu_b_sel = classBSel;
        end
      end
      default: ;
    endcase
    // Reset abandons any in-flight transaction in the same cycle.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign halted = (curState == HALT);
  assign state  = curState;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState      <= FETCH;
      retired_count <= '0;
    end else begin
      if (retire) retired_count <= retired_count + CNT_W'(1);
      case (curState)
        FETCH:  if (mem_ready) curState <= DECODE;
        DECODE: curState <= (opClass == OP_ILLEGAL) ? HALT : EXEC;
        EXEC: begin
          case (opClass)
            OP_LOAD, OP_STORE:             curState <= MEM;
            OP_BRANCH, OP_JAL, OP_JALR:    curState <= FETCH;
            default:                       curState <= WB;
          endcase
        end
        MEM:    if (mem_ready) curState <= (opClass == OP_LOAD) ? WB : FETCH;
        WB:     curState <= FETCH;
        HALT:   curState <= HALT;
        default: curState <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (CNT_W=4): traces each instruction
// cycle by cycle and compares against hand-derived sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, branch_taken, mem_ready;
  logic [31:0] inst;
  logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_sel, reg_write;
  logic [1:0] wb_sel, alu_a_sel;
  logic       alu_b_sel, retire, halted;
  logic [3:0] retired_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .inst(inst), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .retire(retire), .retired_count(retired_count), .halted(halted), .state(state)
  );

  typedef struct {
    logic [2:0] st;
    logic       req, we, asel, mdrw, pcw, pcs, rw, ret, alub;
    logic [1:0] wbs, alua;
    logic [3:0] cnt;
  } snapT;

  snapT tr[64];
  int   trLen;
  int   nChecks = 0;
  int   nFails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until its retire pulse, recording a trace.
  task automatic runInstr(input string tag, input logic [31:0] instr, input int fWait,
                          input int mWait, input logic taken, input int expCycles);
    int fc;
    int mc;
    bit done;
    fc = 0;
    mc = 0;
    done = 1'b0;
    inst = instr;
    branch_taken = taken;
    trLen = 0;
    while (!done && trLen < 60) begin
      mem_ready = 1'b0;
      if (state == 3'd0) begin
        mem_ready = (fc >= fWait);
        fc++;
      end else if (state == 3'd3) begin
        mem_ready = (mc >= mWait);
        mc++;
      end
      #1;
      tr[trLen] = '{st: state, req: mem_req, we: mem_we, asel: addr_sel, mdrw: mdr_write,
                    pcw: pc_write, pcs: pc_sel, rw: reg_write, ret: retire, alub: alu_b_sel,
                    wbs: wb_sel, alua: alu_a_sel, cnt: retired_count};
      trLen++;
      done = retire;
      cyc();
    end
    check({tag, " cycles"}, trLen, expCycles);
  endtask

  initial begin
    int expSt[4];
    logic anyRw;
    logic anyReq;

    reset = 1'b1;
    inst = 32'h0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    check("rst mem_req", mem_req, 1'b0);
    check("rst retire", retire, 1'b0);
    check("rst state", state, 3'd0);
    reset = 1'b0;
    #1;
    check("post-rst state", state, 3'd0);
    check("post-rst count", retired_count, 4'd0);
    check("post-rst halted", halted, 1'b0);
    check("fetch mem_req", mem_req, 1'b1);
    check("fetch addr_sel", addr_sel, 1'b0);
    cyc();

    // ADDI x1,x0,1
    runInstr("addi", 32'h00100093, 0, 0, 1'b0, 4);
    expSt = '{0, 1, 2, 4};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("addi st%0d", i), tr[i].st, expSt[i]);
      check($sformatf("addi rw%0d", i), tr[i].rw, (i == 3));
    end
    check("addi exec alub", tr[2].alub, 1'b1);
    check("addi wb pcw", tr[3].pcw, 1'b1);
    check("addi cnt in wb", tr[3].cnt, 4'd0);
    check("addi count", retired_count, 4'd1);

    // LW x1,0(x0): 3 fetch waits, 2 mem waits
    runInstr("lw", 32'h00002083, 3, 2, 1'b0, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("lw st%0d", i), tr[i].st,
            (i < 4) ? 3'd0 : (i == 4) ? 3'd1 : (i == 5) ? 3'd2 : (i < 9) ? 3'd3 : 3'd4);
      check($sformatf("lw mdrw%0d", i), tr[i].mdrw, (i == 8));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw freq%0d", i), {tr[i].req, tr[i].asel, tr[i].we}, 3'b100);
    end
    for (int i = 6; i < 9; i++) begin
      check($sformatf("lw mreq%0d", i), {tr[i].req, tr[i].asel, tr[i].we}, 3'b110);
    end
    check("lw wb_sel", tr[9].wbs, 2'b01);
    check("lw wb rw", tr[9].rw, 1'b1);
    check("lw count", retired_count, 4'd2);

    // BEQ taken then not taken
    runInstr("beq_t", 32'h00000063, 0, 0, 1'b1, 3);
    anyRw = tr[0].rw | tr[1].rw | tr[2].rw;
    check("beq_t pc_sel", tr[2].pcs, 1'b1);
    check("beq_t pcw", tr[2].pcw, 1'b1);
    check("beq_t no rw", anyRw, 1'b0);
    runInstr("beq_nt", 32'h00000063, 0, 0, 1'b0, 3);
    anyRw = tr[0].rw | tr[1].rw | tr[2].rw;
    check("beq_nt pc_sel", tr[2].pcs, 1'b0);
    check("beq_nt pcw", tr[2].pcw, 1'b1);
    check("beq_nt no rw", anyRw, 1'b0);
    check("beq count", retired_count, 4'd4);

    // JALR x1,0(x1)
    runInstr("jalr", 32'h000080E7, 0, 0, 1'b0, 3);
    check("jalr st", tr[2].st, 3'd2);
    check("jalr pcw/pcs/rw/ret", {tr[2].pcw, tr[2].pcs, tr[2].rw, tr[2].ret}, 4'b1111);
    check("jalr wb_sel", tr[2].wbs, 2'b10);
    check("jalr alu_a", tr[2].alua, 2'b00);
    check("jalr alu_b", tr[2].alub, 1'b1);
    check("jalr count", retired_count, 4'd5);

    // SW x1,0(x0) with one mem wait
    runInstr("sw", 32'h00102023, 0, 1, 1'b0, 5);
    check("sw wait we/ret", {tr[3].req, tr[3].we, tr[3].ret}, 3'b110);
    check("sw ready we/ret", {tr[4].req, tr[4].we, tr[4].ret, tr[4].pcw, tr[4].pcs}, 5'b11110);
    check("sw addr_sel", tr[4].asel, 1'b1);
    check("sw count", retired_count, 4'd6);

    runInstr("lui", 32'h000010B7, 0, 0, 1'b0, 4);
    check("lui exec alu", {tr[2].alua, tr[2].alub}, 3'b101);
    check("lui wb alu", {tr[3].alua, tr[3].wbs}, 4'b1000);
    runInstr("auipc", 32'h00001097, 0, 0, 1'b0, 4);
    check("auipc exec alu", {tr[2].alua, tr[2].alub}, 3'b011);
    check("auipc count", retired_count, 4'd8);

    // ECALL halts after DECODE
    inst = 32'h00000073;
    mem_ready = 1'b1;
    #1;
    check("ecall ir_write", ir_write, 1'b1);
    cyc();
    check("ecall decode", state, 3'd1);
    cyc();
    check("ecall halt st", state, 3'd5);
    check("ecall halted", halted, 1'b1);
    anyReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      anyReq |= mem_req | retire | pc_write;
      cyc();
    end
    check("halt quiet", anyReq, 1'b0);
    check("halt sticky", state, 3'd5);
    check("halt count", retired_count, 4'd8);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("halt rst st", state, 3'd0);
    check("halt rst cnt", retired_count, 4'd0);
    check("halt rst halted", halted, 1'b0);

    // 16 JALs wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      runInstr($sformatf("jal%0d", k), 32'h0000006F, 0, 0, 1'b0, 3);
      if (k == 14) check("jal count 15", retired_count, 4'd15);
    end
    check("jal wrap", retired_count, 4'd0);

    // Reset in the middle of a store's MEM phase
    inst = 32'h00102023;
    mem_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b0;
    #1;
    check("abort mem st", state, 3'd3);
    check("abort mem req/we", {mem_req, mem_we}, 2'b11);
    cyc();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("abort rst req/we", {mem_req, mem_we}, 2'b00);
    check("abort rst ret/pcw", {retire, pc_write}, 2'b00);
    cyc();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("abort post st", state, 3'd0);
    check("abort post cnt", retired_count, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences a shared-memory, multi-cycle RV32I datapath (PC, IR, MDR, register file, ALU). It issues fetch and load/store requests on one memory port, drives the datapath enables and mux selects per state, and counts retired instructions. It decodes the opcode field itself, so it needs no separate decoder instance. It halts on SYSTEM or unsupported opcodes.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- inst  in  32  IR contents; valid from DECODE onward, only inst[6:0] used
- branch_taken  in  1  datapath comparator result for the current branch; sampled in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe; qualified by mem_req
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  update PC
- pc_sel  out  1  next PC: 0 = PC+4, 1 = ALU result (datapath clears bit 0)
- reg_write  out  1  write rd
- wb_sel  out  2  rd source: 00 = ALU, 01 = MDR, 10 = PC+4
- alu_a_sel  out  2  00 = rs1, 01 = PC, 10 = zero
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- retire  out  1  one-cycle pulse per completed instruction
- retired_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- halted  out  1  FSM is in HALT
- state  out  3  state encoding for debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5

## Operation
- Opcode classes (inst[6:0]): ALUreg 0110011, ALUimm 0010011, BRANCH 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111, LOAD 0000011, STORE 0100011. Anything else, including SYSTEM 1110011, is illegal.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. Hold until mem_ready=1. In the mem_ready cycle: ir_write=1, then go to DECODE.
- DECODE: no enables asserted. Illegal opcode → HALT; otherwise → EXEC.
- EXEC, per class:
  - ALUreg: a=rs1, b=rs2 → WB.
  - ALUimm: a=rs1, b=imm → WB.
  - LUI: a=zero, b=imm → WB.
  - AUIPC: a=PC, b=imm → WB.
  - LOAD/STORE: a=rs1, b=imm → MEM.
  - BRANCH: a=PC, b=imm; pc_write=1, pc_sel=branch_taken, retire=1 → FETCH.
  - JAL: a=PC, b=imm; JALR: a=rs1, b=imm. Both assert pc_write=1, pc_sel=1, reg_write=1, wb_sel=10, retire=1 → FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=(STORE), ALU selects held as in EXEC. Hold until mem_ready=1. In the mem_ready cycle:
  - LOAD: mdr_write=1 → WB.
  - STORE: pc_write=1, pc_sel=0, retire=1 → FETCH.
- WB: reg_write=1, wb_sel=01 for LOAD, 00 otherwise. ALU selects held for non-load classes. pc_write=1, pc_sel=0, retire=1 → FETCH.
- HALT: all enables 0, halted=1. Sticky until reset.
- retired_count increments on every retire pulse; rolls from all-ones to 0.
- Any output not listed for a state is 0 in that state.

## Timing
- Reset: next edge enters FETCH. retired_count=0, halted=0. All strobes (mem_req, mem_we, ir_write, mdr_write, pc_write, reg_write, retire) are 0 during the reset cycle. Reset mid-request abandons the transaction; mem_req drops in the reset cycle.
- mem_req, mem_we and addr_sel stay stable from assertion until the cycle mem_ready=1. mem_ready is ignored when mem_req=0.
- Cycles per instruction with zero-wait memory (mem_ready already high):
  - BRANCH/JAL/JALR: 3.
  - ALU/LUI/AUIPC/STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds 1.
- The retire pulse coincides with the final pc_write. retired_count shows the new value on the following cycle.
- Outputs are combinational from state and inst. State and counter are registered.

## Test plan
- Reset then ADDI (0x00100093), mem_ready tied 1 → states 0,1,2,4,0; reg_write only in WB; retire once; retired_count=1.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEM → mem_req/addr_sel stable throughout; mdr_write on MEM ready cycle; total 10 cycles; wb_sel=01 in WB.
- BEQ with branch_taken=1, then with branch_taken=0 → 3 cycles each; pc_sel=1 then 0; reg_write never asserted.
- JALR (0x000080E7) → EXEC asserts pc_write, pc_sel=1, reg_write, wb_sel=10, alu_a_sel=00, alu_b_sel=1.
- Opcode 0x00000073 (ECALL) → HALT after DECODE; halted=1; no further mem_req; reset returns FETCH with count 0.
- CNT_W=4, 16 back-to-back JALs → retired_count wraps 15→0; reset asserted mid-MEM of a store → mem_req drops, mem_we never reaches an accepted cycle.
